// File: rtl/hazard_detection_unit_if.sv
// Pipeline-facing signal bundle of the hazard detection unit.
interface hazard_detection_unit_if;
  logic [4:0]  IF_ID_RS_i;
  logic [4:0]  IF_ID_RT_i;
  logic [4:0]  ID_EX_RT_i;
  logic        ID_EX_mem_read_i;
  logic        branch_taken_i;
  logic        dmem_busy_i;
  logic        PC_write_o;
  logic        IF_ID_write_o;
  logic        IF_ID_flush_o;
  logic        ID_EX_flush_o;
  logic        pipe_hold_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  // Pipeline side: supplies hazard sources, consumes control.
  modport master (
    output IF_ID_RS_i, IF_ID_RT_i, ID_EX_RT_i, ID_EX_mem_read_i,
           branch_taken_i, dmem_busy_i,
    input  PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_flush_o,
           pipe_hold_o, state_o, stall_cnt_o, flush_cnt_o
  );

  // Hazard unit side.
  modport slave (
    input  IF_ID_RS_i, IF_ID_RT_i, ID_EX_RT_i, ID_EX_mem_read_i,
           branch_taken_i, dmem_busy_i,
    output PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_flush_o,
           pipe_hold_o, state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// Hazard detection: picks one pipeline action per cycle (MEM_WAIT > FLUSH >
// LOAD_STALL > RUN), remembers branches that arrive while memory is busy,
// and keeps saturating stall/flush statistics.
module hazard_detection_unit (
  input  logic                    clk_i,
  input  logic                    rst_i,
  hazard_detection_unit_if.slave  bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ACT_RUN        = 2'd0,
    ACT_LOAD_STALL = 2'd1,
    ACT_FLUSH      = 2'd2,
    ACT_MEM_WAIT   = 2'd3
  } action_t;

  action_t          action;
  action_t          state_q;
  logic             load_use;
  logic             flush_req;
  logic             pending_flush_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Classify the current cycle from live inputs and the deferred flush.
  always_comb begin
    load_use  = bus.ID_EX_mem_read_i && (bus.ID_EX_RT_i != 5'd0) &&
                ((bus.ID_EX_RT_i == bus.IF_ID_RS_i) ||
                 (bus.ID_EX_RT_i == bus.IF_ID_RT_i));
    flush_req = bus.branch_taken_i || pending_flush_q;
    action    = ACT_RUN;
    if (bus.dmem_busy_i) begin
      action = ACT_MEM_WAIT;
    end else if (flush_req) begin
      action = ACT_FLUSH;
    end else if (load_use) begin
      action = ACT_LOAD_STALL;
    end
  end

  // Decode the action into pipeline controls; reset forces RUN controls.
  always_comb begin
    bus.PC_write_o    = 1'b1;
    bus.IF_ID_write_o = 1'b1;
    bus.IF_ID_flush_o = 1'b0;
    bus.ID_EX_flush_o = 1'b0;
    bus.pipe_hold_o   = 1'b0;
    if (!rst_i) begin
      case (action)
        ACT_MEM_WAIT: begin
          bus.PC_write_o    = 1'b0;
          bus.IF_ID_write_o = 1'b0;
          bus.pipe_hold_o   = 1'b1;
        end
        ACT_FLUSH: begin
          bus.IF_ID_flush_o = 1'b1;
          bus.ID_EX_flush_o = 1'b1;
        end
        ACT_LOAD_STALL: begin
          bus.PC_write_o    = 1'b0;
          bus.IF_ID_write_o = 1'b0;
          bus.ID_EX_flush_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Record the applied action, defer branches seen during MEM_WAIT, count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ACT_RUN;
      pending_flush_q <= 1'b0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
    end else begin
      state_q <= action;
      if (action == ACT_FLUSH) begin
        pending_flush_q <= 1'b0;
      end else if ((action == ACT_MEM_WAIT) && bus.branch_taken_i) begin
        pending_flush_q <= 1'b1;
      end
      if (((action == ACT_LOAD_STALL) || (action == ACT_MEM_WAIT)) &&
          (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if ((action == ACT_FLUSH) && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.state_o     = state_q;
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk_i is the clock and rst_i is the reset, sampled on the rising edge of clk_i.
REQ-002 clk_i  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 IF_ID_RS_i  input  5  rs field of instruction in ID.
REQ-005 IF_ID_RT_i  input  5  rt field of instruction in ID.
REQ-006 ID_EX_RT_i  input  5  destination (rt) of instruction in EX.
REQ-007 ID_EX_mem_read_i  input  1  instruction in EX is a load.
REQ-008 branch_taken_i  input  1  branch/jump resolved taken in EX this cycle.
REQ-009 dmem_busy_i  input  1  data memory not ready; whole pipeline must hold.
REQ-010 PC_write_o  output  1  1 = PC may update.
REQ-011 IF_ID_write_o  output  1  1 = IF/ID register may update.
REQ-012 IF_ID_flush_o  output  1  1 = IF/ID loads a NOP.
REQ-013 ID_EX_flush_o  output  1  1 = ID/EX control bits zeroed (bubble).
REQ-014 pipe_hold_o  output  1  1 = ID/EX, EX/MEM, MEM/WB hold their values.
REQ-015 state_o  output  2  registered action of the previous cycle: 0 RUN, 1 LOAD_STALL, 2 FLUSH, 3 MEM_WAIT.
REQ-016 stall_cnt_o  output  16  saturating count of stall cycles.
REQ-017 flush_cnt_o  output  16  saturating count of applied flushes.

Function
REQ-018 load_use SHALL be ID_EX_mem_read_i && ID_EX_RT_i != 0 && (ID_EX_RT_i == IF_ID_RS_i || ID_EX_RT_i == IF_ID_RT_i).
REQ-019 flush_req SHALL be branch_taken_i || pending_flush, where pending_flush is an internal register.
REQ-020 Each cycle's action SHALL be chosen combinationally from the current inputs and pending_flush, in priority order MEM_WAIT > FLUSH > LOAD_STALL > RUN.
REQ-021 MEM_WAIT (dmem_busy_i=1): PC_write_o=0, IF_ID_write_o=0, pipe_hold_o=1, IF_ID_flush_o=0, ID_EX_flush_o=0.
REQ-022 FLUSH (busy=0, flush_req=1): PC_write_o=1, IF_ID_write_o=1, IF_ID_flush_o=1, ID_EX_flush_o=1, pipe_hold_o=0; load_use is ignored this cycle.
REQ-023 LOAD_STALL (busy=0, flush_req=0, load_use=1): PC_write_o=0, IF_ID_write_o=0, ID_EX_flush_o=1, IF_ID_flush_o=0, pipe_hold_o=0.
REQ-024 RUN (otherwise): PC_write_o=1, IF_ID_write_o=1, all flush and hold outputs 0.
REQ-025 Action-selection latency SHALL be zero cycles; control outputs depend combinationally on the current inputs.
REQ-026 If branch_taken_i=1 while dmem_busy_i=1, pending_flush SHALL be set at the next edge; it SHALL stay set until a FLUSH cycle is applied, then clear at that edge.
REQ-027 Simultaneous branch_taken_i and pending_flush SHALL produce exactly one FLUSH cycle and one flush_cnt_o increment.
REQ-028 state_o SHALL register the encoding of the current action at each rising edge.
REQ-029 stall_cnt_o SHALL increment by 1 at each edge whose action is LOAD_STALL or MEM_WAIT, and saturate at 16'hFFFF.
REQ-030 flush_cnt_o SHALL increment by 1 at each edge whose action is FLUSH, and saturate at 16'hFFFF.
REQ-031 Register 0 SHALL never trigger load_use, even when IF_ID_RS_i=0 or IF_ID_RT_i=0.
REQ-032 After a LOAD_STALL cycle the bubble in EX removes load_use; a back-to-back stall SHALL occur only if a new load is again in EX with a matching destination.

Reset
REQ-033 With rst_i=1 at an edge: pending_flush=0, state_o=0, stall_cnt_o=0, flush_cnt_o=0.
REQ-034 While rst_i=1, control outputs SHALL be forced to RUN values (PC_write_o=1, IF_ID_write_o=1, flushes 0, pipe_hold_o=0), whatever the other inputs are.
REQ-035 Reset during MEM_WAIT with a pending flush SHALL discard the pending flush; no FLUSH cycle follows reset.

Verification
REQ-036 Load-use: mem_read=1, ID_EX_RT=5, IF_ID_RS=5 for 1 cycle -> PC_write=0, IF_ID_write=0, ID_EX_flush=1; next state_o=1; stall_cnt=1.
REQ-037 Zero register: mem_read=1, ID_EX_RT=0, IF_ID_RS=0 -> RUN; stall_cnt stays 0.
REQ-038 Branch plus load-use in the same cycle -> FLUSH only; flush_cnt=1, stall_cnt=0, state_o=2.
REQ-039 Branch during busy: busy=1 for 3 cycles, branch_taken=1 in the 2nd cycle -> 3 MEM_WAIT cycles, then 1 FLUSH cycle with branch_taken=0; stall_cnt=3, flush_cnt=1.
REQ-040 Saturation: force 70000 consecutive busy cycles -> stall_cnt_o=16'hFFFF and it holds there.
REQ-041 Reset mid-operation: set pending_flush, assert rst_i for 1 cycle -> all counters 0, state_o=0, and no FLUSH on the following cycle.
